// File: rtl/npc_lsu_pkg.sv
// Shared encodings for the load/store unit: mem_bits codes, FSM states and access-size decode.
package npc_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Stores look only at the low two bits; unknown codes fall back to word.
  function automatic size_t access_size(input logic wr, input logic [2:0] bits);
    size_t sz;
    sz = SZ_W;
    if (wr) begin
      case (bits[1:0])
        SB[1:0]: sz = SZ_B;
        SH[1:0]: sz = SZ_H;
        SW[1:0]: sz = SZ_W;
        default: sz = SZ_W;
      endcase
    end else begin
      case (bits)
        LB, LBU: sz = SZ_B;
        LH, LHU: sz = SZ_H;
        LW:      sz = SZ_W;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes and replication, load lane select and extension.
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic        mem_wr,
  input  logic [2:0]  mem_bits,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  ld_bits,
  input  logic [1:0]  ld_off,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  always_comb begin
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    case (access_size(mem_wr, mem_bits))
      SZ_B: begin
        wstrb     = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        wstrb     = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Shift the addressed byte down to lane 0, then extend by code.
  assign lane = bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = lane;
    case (access_size(1'b0, ld_bits))
      SZ_B:    ld_data = ld_bits[2] ? {24'h0, lane[7:0]} : 32'($signed(lane[7:0]));
      SZ_H:    ld_data = ld_bits[2] ? {16'h0, lane[15:0]} : 32'($signed(lane[15:0]));
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM driving a word bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module lsu
  import npc_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_wr,
  input  logic [2:0]        mem_bits,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misalign_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  state_t            state;
  logic              wr_q;
  logic [2:0]        bits_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [31:0]       bus_wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rdata_q;
  logic [3:0]        wstrb_c;
  logic [31:0]       wdata_rep_c;
  logic [31:0]       ld_data_c;

  lsu_align u_align (
    .mem_wr    (mem_wr),
    .mem_bits  (mem_bits),
    .off       (addr[1:0]),
    .wdata     (wdata),
    .wstrb     (wstrb_c),
    .wdata_rep (wdata_rep_c),
    .ld_bits   (bits_q),
    .ld_off    (off_q),
    .bus_rdata (bus_rdata),
    .ld_data   (ld_data_c)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_q;
  assign misalign_err = misal_q && (state == RESP);
`else
  assign misalign_err = 1'b0;
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign bus_valid  = (state == REQ);
  assign bus_we     = wr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign rdata      = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wstrb_q <= 4'b0000;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q <= 1'b0;
`endif
    end else begin
      case (state)
        // Accept: capture the request and the bus beat it maps to.
        IDLE: begin
          if (req_valid) begin
            wr_q        <= mem_wr;
            bits_q      <= mem_bits;
            off_q       <= addr[1:0];
            bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_q <= wdata_rep_c;
            wstrb_q     <= wstrb_c;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q <= is_misaligned(access_size(mem_wr, mem_bits), addr[1:0]);
            state   <= is_misaligned(access_size(mem_wr, mem_bits), addr[1:0]) ? RESP : REQ;
`else
            state <= REQ;
`endif
          end
        end
        // Command held until the bus takes it.
        REQ: begin
          if (bus_ready) state <= wr_q ? RESP : WAIT_R;
        end
        // Read return: no back-pressure, capture the extended lane.
        WAIT_R: begin
          if (bus_rvalid) begin
            rdata_q <= ld_data_c;
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses against a lane-level model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_wr;
  logic [2:0]  mem_bits;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] o_rdata, o_baddr, o_bwdata, model_rdata;
  logic [3:0]  o_strb;
  logic        o_we, o_err, o_unstable, o_rr_bad;
  int          o_lat, o_bv, o_gap;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .mem_wr       (mem_wr),
    .mem_bits     (mem_bits),
    .addr         (addr),
    .wdata        (wdata),
    .resp_valid   (resp_valid),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  // Reference load result from byte lanes of the returned word (aligned halves only).
  function automatic logic [31:0] ref_load(input logic [2:0] bits, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (bits)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Issue one request and act as the memory; results land in the o_* variables.
  task automatic run_op(input logic wr, input logic [2:0] bits, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rword, input int rdy_wait);
    int   waited;
    logic hs_prev;
    logic first;
    mem_wr = wr; mem_bits = bits; addr = a; wdata = wd; req_valid = 1'b1;
    o_gap = 0;
    while (!req_ready && o_gap < 20) begin
      @(posedge clk); #1; o_gap++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_wr = 1'($urandom); mem_bits = 3'($urandom); addr = $urandom; wdata = $urandom;
    o_lat = -1; o_bv = 0; o_unstable = 1'b0; o_rr_bad = 1'b0; o_err = 1'b0;
    o_baddr = 32'h0; o_bwdata = 32'h0; o_strb = 4'h0; o_we = 1'b0; o_rdata = 32'h0;
    waited = 0; hs_prev = 1'b0; first = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      bus_ready  = 1'b0;
      bus_rvalid = hs_prev && !wr;
      bus_rdata  = bus_rvalid ? rword : $urandom;
      hs_prev    = 1'b0;
      if (resp_valid) begin
        o_lat = k; o_rdata = rdata; o_err = misalign_err;
        break;
      end
      if (req_ready) o_rr_bad = 1'b1;
      if (bus_valid) begin
        o_bv++;
        if (first) begin
          o_baddr = bus_addr; o_bwdata = bus_wdata; o_strb = bus_wstrb; o_we = bus_we;
          first = 1'b0;
        end else if (o_baddr !== bus_addr || o_bwdata !== bus_wdata ||
                     o_strb !== bus_wstrb || o_we !== bus_we) begin
          o_unstable = 1'b1;
        end
        if (waited < rdy_wait) waited++;
        else begin
          bus_ready = 1'b1; hs_prev = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_cmp++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bus_valid: got %b want 0", bus_valid); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b want 0", misalign_err); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (bus_wstrb !== 4'h0) begin n_fail++; $display("FAIL rst_wstrb: got %b want 0000", bus_wstrb); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    model_rdata = 32'h0;
  endtask

  task automatic test_directed_loads;
    run_op(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 0);
    n_cmp++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
    n_cmp++; if (o_baddr !== 32'h80000000) begin n_fail++; $display("FAIL lb_addr: got %h want 80000000", o_baddr); end
    n_cmp++; if (o_lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", o_lat); end
    n_cmp++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", o_we); end
    run_op(1'b0, 3'b101, 32'h80000002, 32'h0, 32'hBEEF1234, 0);
    n_cmp++; if (o_rdata !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_rdata: got %h want 0000beef", o_rdata); end
    model_rdata = 32'h0000BEEF;
  endtask

  task automatic test_directed_store;
    run_op(1'b1, 3'b001, 32'h80000006, 32'h1234ABCD, 32'h0, 0);
    n_cmp++; if (o_baddr !== 32'h80000004) begin n_fail++; $display("FAIL sh_addr: got %h want 80000004", o_baddr); end
    n_cmp++; if (o_strb !== 4'b1100) begin n_fail++; $display("FAIL sh_strb: got %b want 1100", o_strb); end
    n_cmp++; if (o_bwdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", o_bwdata); end
    n_cmp++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", o_we); end
    n_cmp++; if (o_lat !== 2) begin n_fail++; $display("FAIL sh_latency: got %0d want 2", o_lat); end
    n_cmp++; if (o_rdata !== model_rdata) begin n_fail++; $display("FAIL sh_rdata_held: got %h want %h", o_rdata, model_rdata); end
  endtask

  task automatic test_backpressure;
    run_op(1'b1, 3'b010, 32'h80000010, 32'h5A5AC3C3, 32'h0, 5);
    n_cmp++; if (o_bv !== 6) begin n_fail++; $display("FAIL bp_valid_cycles: got %0d want 6", o_bv); end
    n_cmp++; if (o_unstable !== 1'b0) begin n_fail++; $display("FAIL bp_stable: got %b want 0", o_unstable); end
    n_cmp++; if (o_rr_bad !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready_low: got %b want 0", o_rr_bad); end
    n_cmp++; if (o_lat !== 7) begin n_fail++; $display("FAIL bp_latency: got %0d want 7", o_lat); end
    n_cmp++; if (o_strb !== 4'hF || o_bwdata !== 32'h5A5AC3C3) begin
      n_fail++; $display("FAIL bp_beat: got %b/%h want 1111/5a5ac3c3", o_strb, o_bwdata);
    end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back;
    run_op(1'b1, 3'b000, 32'h80000101, 32'h000000A5, 32'h0, 0);
    n_cmp++; if (o_strb !== 4'b0010 || o_bwdata !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL b2b_sb_beat: got %b/%h want 0010/a5a5a5a5", o_strb, o_bwdata);
    end
    run_op(1'b0, 3'b001, 32'h80000102, 32'h0, 32'h8001FFFF, 0);
    n_cmp++; if (o_gap !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", o_gap); end
    n_cmp++; if (o_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL b2b_lh_rdata: got %h want ffff8001", o_rdata); end
    n_cmp++; if (o_lat !== 3) begin n_fail++; $display("FAIL b2b_lh_latency: got %0d want 3", o_lat); end
    model_rdata = 32'hFFFF8001;
  endtask

  task automatic test_random;
    logic        wr;
    logic [2:0]  bits;
    logic [31:0] a, wd, rw, exp_d;
    logic [3:0]  exp_s;
    int          sz, rw_wait;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      bits = 3'($urandom_range(0, 7));
      if (wr) sz = (bits[1:0] == 2'd0) ? 1 : (bits[1:0] == 2'd1) ? 2 : 4;
      else sz = (bits == 3'd0 || bits == 3'd4) ? 1 : (bits == 3'd1 || bits == 3'd5) ? 2 : 4;
      a = $urandom & ~(32'(sz) - 32'd1);
      wd = $urandom; rw = $urandom;
      rw_wait = $urandom_range(0, 2);
      run_op(wr, bits, a, wd, rw, rw_wait);
      if (!wr) model_rdata = ref_load(bits, a[1:0], rw);
      n_cmp++; if (o_lat !== (wr ? 2 : 3) + rw_wait) begin
        n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, o_lat, (wr ? 2 : 3) + rw_wait);
      end
      n_cmp++; if (o_baddr !== (a & 32'hFFFFFFFC) || o_we !== wr) begin
        n_fail++; $display("FAIL rnd_cmd[%0d]: got %h/%b want %h/%b", i, o_baddr, o_we, a & 32'hFFFFFFFC, wr);
      end
      n_cmp++; if (o_rdata !== model_rdata) begin
        n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, o_rdata, model_rdata);
      end
      if (wr) begin
        exp_s = (sz == 1) ? 4'(1 << a[1:0]) : (sz == 2) ? 4'(3 << a[1:0]) : 4'hF;
        exp_d = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        n_cmp++; if (o_strb !== exp_s || o_bwdata !== exp_d) begin
          n_fail++; $display("FAIL rnd_store[%0d]: got %b/%h want %b/%h", i, o_strb, o_bwdata, exp_s, exp_d);
        end
      end
    end
  endtask

  task automatic test_misalign;
    run_op(1'b0, 3'b010, 32'h80000001, 32'h0, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (o_lat !== 1) begin n_fail++; $display("FAIL mis_lw_latency: got %0d want 1", o_lat); end
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL mis_lw_err: got %b want 1", o_err); end
    n_cmp++; if (o_bv !== 0) begin n_fail++; $display("FAIL mis_lw_no_bus: got %0d want 0", o_bv); end
    n_cmp++; if (o_rdata !== model_rdata) begin n_fail++; $display("FAIL mis_lw_rdata: got %h want %h", o_rdata, model_rdata); end
    run_op(1'b1, 3'b001, 32'h80000003, 32'h0000BEEF, 32'h0, 0);
    n_cmp++; if (o_lat !== 1 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL mis_sh_trap: got lat %0d err %b want lat 1 err 1", o_lat, o_err);
    end
`else
    n_cmp++; if (o_strb !== 4'hF) begin n_fail++; $display("FAIL mis_lw_strb: got %b want 1111", o_strb); end
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL mis_lw_err: got %b want 0", o_err); end
    n_cmp++; if (o_lat !== 3 || o_baddr !== 32'h80000000) begin
      n_fail++; $display("FAIL mis_lw_cmd: got lat %0d addr %h want lat 3 addr 80000000", o_lat, o_baddr);
    end
    run_op(1'b1, 3'b001, 32'h80000003, 32'h0000BEEF, 32'h0, 0);
    n_cmp++; if (o_strb !== 4'b1000 || o_bwdata !== 32'hBEEFBEEF || o_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_sh_strb: got %b/%h/%b want 1000/beefbeef/0", o_strb, o_bwdata, o_err);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic seen;
    run_op(1'b0, 3'b010, 32'h80000040, 32'h0, 32'h12345678, 0);
    n_cmp++; if (o_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rm_pre_rdata: got %h want 12345678", o_rdata); end
    @(posedge clk); #1;
    mem_wr = 1'b0; mem_bits = 3'b010; addr = 32'h80000020; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req_ready: got %b want 1", req_ready); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen = seen | resp_valid | bus_valid;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp: got %b want 0", seen); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", rdata); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_idle: got %b want 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_wr = 1'b0; mem_bits = 3'b0; addr = 32'h0; wdata = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    model_rdata = 32'h0;
    #1;
    test_reset;
    test_directed_loads;
    test_directed_store;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_misalign;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
